// File: rtl/pwm_cfg_sched.sv
// rtl/pwm_cfg_sched.sv - shadow/active PWM configuration scheduler with frame-synced commit and watchdog failsafe
module pwm_cfg_sched #(
  parameter int              NCH           = 4,
  parameter logic [23:0]     WD_CYCLES     = 24'd10_000_000,
  parameter logic [15:0]     FAILSAFE_DUTY = 16'h0000,
  parameter logic [NCH-1:0]  FAILSAFE_EN   = '0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               wr_en,
  input  logic [7:0]         addr,
  input  logic [7:0]         wdata,
  input  logic               sync_tick,
  output logic [NCH-1:0]     pwm_on,
  output logic [8*NCH-1:0]   pwm_duty_l,
  output logic [8*NCH-1:0]   pwm_duty_h,
  output logic [8*NCH-1:0]   pwm_freq_l,
  output logic [8*NCH-1:0]   pwm_freq_h,
  output logic               commit_pending,
  output logic               commit_done,
  output logic               failsafe
);

  typedef enum logic [1:0] {IDLE, PENDING, APPLY, FAILSAFE} stateE;

  stateE state, nextState;

  logic [8*NCH-1:0] shDutyL, shDutyH, shPerL, shPerH;
  logic [NCH-1:0]   shMask;
  logic [23:0]      wdCount;

  logic       chWr, maskWr, commitWr, wdExpire;
  logic [2:0] chSel;
  logic [1:0] regSel;
  logic       pendNext, doneNext, failNext;

  // Channel registers live in 0x00-0x1F; the loop below drops channels >= NCH.
  assign chSel    = addr[4:2];
  assign regSel   = addr[1:0];
  assign chWr     = wr_en && (addr[7:5] == 3'b000);
  assign maskWr   = wr_en && (addr == 8'h20);
  assign commitWr = wr_en && (addr == 8'h21);

  // The watchdog only runs while the host is expected to be committing.
  assign wdExpire = (WD_CYCLES != 24'd0) && ((state == IDLE) || (state == PENDING)) &&
                    (wdCount == WD_CYCLES - 24'd1);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= nextState;
  end

  // Next-state logic; watchdog expiry beats both commit and sync_tick
  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (wdExpire) nextState = FAILSAFE;
                else if (commitWr) nextState = PENDING;
      PENDING:  if (wdExpire) nextState = FAILSAFE;
                else if (sync_tick) nextState = APPLY;
      APPLY:    nextState = IDLE;
      FAILSAFE: if (commitWr) nextState = PENDING;
      default:  nextState = IDLE;
    endcase
  end

  // Output decode, computed one cycle early so the status flags leave the block registered
  always_comb begin
    pendNext = (nextState == PENDING) || (nextState == APPLY);
    doneNext = (state == APPLY);
    failNext = failsafe;
    if (state == APPLY)               failNext = 1'b0;
    else if (nextState == FAILSAFE)   failNext = 1'b1;
  end

  // Registered status flags; failsafe stays up through PENDING until an APPLY lands
  always_ff @(posedge clk) begin
    if (!resetn) begin
      commit_pending <= 1'b0;
      commit_done    <= 1'b0;
      failsafe       <= 1'b0;
    end else begin
      commit_pending <= pendNext;
      commit_done    <= doneNext;
      failsafe       <= failNext;
    end
  end

  // Watchdog counter; zeroed on expiry so recovery from FAILSAFE gets a full window
  always_ff @(posedge clk) begin
    if (!resetn)                                  wdCount <= 24'd0;
    else if ((state == APPLY) || wdExpire)        wdCount <= 24'd0;
    else if ((state == IDLE) || (state == PENDING)) wdCount <= wdCount + 24'd1;
  end

  // Shadow registers accept host writes in every state; latest write wins
  always_ff @(posedge clk) begin
    if (!resetn) begin
      shDutyL <= '0;
      shDutyH <= '0;
      shPerL  <= '0;
      shPerH  <= '0;
      shMask  <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (chWr && (chSel == 3'(c))) begin
          case (regSel)
            2'd0:    shDutyL[8*c +: 8] <= wdata;
            2'd1:    shDutyH[8*c +: 8] <= wdata;
            2'd2:    shPerL[8*c +: 8]  <= wdata;
            default: shPerH[8*c +: 8]  <= wdata;
          endcase
        end
      end
      if (maskWr) shMask <= wdata[NCH-1:0];
    end
  end

  // Active registers: bulk copy in APPLY (pre-write shadow values), failsafe override on expiry
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pwm_duty_l <= '0;
      pwm_duty_h <= '0;
      pwm_freq_l <= '0;
      pwm_freq_h <= '0;
      pwm_on     <= '0;
    end else if (state == APPLY) begin
      pwm_duty_l <= shDutyL;
      pwm_duty_h <= shDutyH;
      pwm_freq_l <= shPerL;
      pwm_freq_h <= shPerH;
      pwm_on     <= shMask;
    end else if ((nextState == FAILSAFE) && (state != FAILSAFE)) begin
      pwm_duty_l <= {NCH{FAILSAFE_DUTY[7:0]}};
      pwm_duty_h <= {NCH{FAILSAFE_DUTY[15:8]}};
      pwm_on     <= FAILSAFE_EN;
    end
  end

endmodule
